// File: rtl/nmr_seq_pkg.sv
// -----------------------------------------------------------------------------
// nmr_seq_pkg
// Shared definitions for the NMR multi-scan sequencer.
//   seq_state_t         one-hot sequencer state encoding
//   STATE_W             width of the state vector
//   ACK_TIMEOUT_DEFAULT default cycles to wait for the pulse program to ack
//   cnt_width()         counter width able to hold values 0..max_val
// -----------------------------------------------------------------------------
package nmr_seq_pkg;

    localparam int STATE_W = 6;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = 6'b000001,
        S_LAUNCH   = 6'b000010,
        S_WAIT_END = 6'b000100,
        S_REPT_DLY = 6'b001000,
        S_DRAIN    = 6'b010000,
        S_FINISH   = 6'b100000
    } seq_state_t;

    localparam int ACK_TIMEOUT_DEFAULT = 1024;

    // Width of a counter that must reach max_val; never less than one bit.
    function automatic int cnt_width(input int max_val);
        if (max_val < 2) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/nmr_rept_delay_timer.sv
// -----------------------------------------------------------------------------
// nmr_rept_delay_timer
// Down-counter that times the idle gap between two scans.
//   CLK, RESET  clock and asynchronous active-high reset
//   load        loads 'value' into the counter (value must be non-zero)
//   value       number of cycles to time
//   expire      high for exactly one cycle: the last cycle of the interval
// With load on edge E, expire is high during the cycle before edge E+value,
// so a consumer that leaves its waiting state on the expire edge spends
// exactly 'value' cycles waiting.
// -----------------------------------------------------------------------------
module nmr_rept_delay_timer #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             expire
);

    logic [WIDTH-1:0] remaining;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= value;
        end else if (remaining != '0) begin
            remaining <= remaining - WIDTH'(1);
        end
    end

    assign expire = (remaining == WIDTH'(1));

endmodule

// File: rtl/nmr_scan_sequencer.sv
// -----------------------------------------------------------------------------
// nmr_scan_sequencer
// Runs NUM_SCANS back-to-back pulse-program scans, separated by REPT_DELAY
// idle cycles, with optional per-scan phase cycling.
//   CLK, RESET   clock and asynchronous active-high reset
//   START        level, sampled only in IDLE to begin a run
//   ABORT        level, ends the run early and sets ERR
//   NUM_SCANS    scans per run (0 gives an immediate DONE, no run)
//   REPT_DELAY   idle cycles between the end of one scan and the next launch
//   PHCYC_EN     toggle PHASE_CYC after every completed, non-final scan
//   PP_FSMSTAT   pulse-program busy flag
//   PP_START     pulse-program start request
//   PHASE_CYC    phase-cycling select
//   SCAN_IDX     number of completed scans in the current/last run
//   BUSY         high from run accept through the FINISH cycle
//   SCAN_DONE    one-cycle pulse per completed scan
//   DONE         one-cycle pulse at the end of a run (or a zero-count START)
//   ERR          sticky: ack timeout or abort; cleared by the next accepted START
//   DBG_STATE    current sequencer state
//
// Pulse-program handshake: PP_START is raised one cycle after LAUNCH is
// entered and held until PP_FSMSTAT is seen high (the ack), which drops
// PP_START and moves to WAIT_END. The scan ends when PP_FSMSTAT falls. No
// ack within ACK_TIMEOUT LAUNCH cycles is an error that ends the run.
// -----------------------------------------------------------------------------
module nmr_scan_sequencer
    import nmr_seq_pkg::*;
#(
    parameter int SCAN_CNT_WIDTH   = 16,
    parameter int REPT_DELAY_WIDTH = 32,
    parameter int ACK_TIMEOUT      = ACK_TIMEOUT_DEFAULT
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        START,
    input  logic                        ABORT,
    input  logic [SCAN_CNT_WIDTH-1:0]   NUM_SCANS,
    input  logic [REPT_DELAY_WIDTH-1:0] REPT_DELAY,
    input  logic                        PHCYC_EN,
    input  logic                        PP_FSMSTAT,
    output logic                        PP_START,
    output logic                        PHASE_CYC,
    output logic [SCAN_CNT_WIDTH-1:0]   SCAN_IDX,
    output logic                        BUSY,
    output logic                        SCAN_DONE,
    output logic                        DONE,
    output logic                        ERR,
    output seq_state_t                  DBG_STATE
);

    localparam int               ACK_W    = cnt_width(ACK_TIMEOUT);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

    seq_state_t                  state;
    logic [SCAN_CNT_WIDTH-1:0]   num_lat;
    logic [REPT_DELAY_WIDTH-1:0] rept_lat;
    logic                        phcyc_lat;
    logic [ACK_W-1:0]            ack_cnt;

    logic [SCAN_CNT_WIDTH-1:0]   next_idx;
    logic                        scan_end;
    logic                        last_scan;
    logic                        abort_now;
    logic                        tmr_load;
    logic                        tmr_expire;

    assign next_idx  = SCAN_IDX + SCAN_CNT_WIDTH'(1);
    assign scan_end  = (state == S_WAIT_END) && !ABORT && !PP_FSMSTAT;
    // Full-width compare: a run of 2^W-1 scans ends before SCAN_IDX can wrap.
    assign last_scan = (next_idx == num_lat);
    // DRAIN and FINISH are already on the way out, so ABORT only acts
    // in the three states of an active scan.
    assign abort_now = ABORT && ((state == S_LAUNCH) ||
                                 (state == S_WAIT_END) ||
                                 (state == S_REPT_DLY));
    assign tmr_load  = scan_end && !last_scan && (rept_lat != '0);

    nmr_rept_delay_timer #(
        .WIDTH (REPT_DELAY_WIDTH)
    ) u_rept_timer (
        .CLK    (CLK),
        .RESET  (RESET),
        .load   (tmr_load),
        .value  (rept_lat),
        .expire (tmr_expire)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            num_lat   <= '0;
            rept_lat  <= '0;
            phcyc_lat <= 1'b0;
            ack_cnt   <= '0;
            PP_START  <= 1'b0;
            PHASE_CYC <= 1'b0;
            SCAN_IDX  <= '0;
            BUSY      <= 1'b0;
            SCAN_DONE <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            SCAN_DONE <= 1'b0;
            DONE      <= 1'b0;

            if (abort_now) begin
                PP_START <= 1'b0;
                ERR      <= 1'b1;
                state    <= PP_FSMSTAT ? S_DRAIN : S_FINISH;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (START && !ABORT) begin
                            if (NUM_SCANS == '0) begin
                                DONE <= 1'b1;
                            end else begin
                                num_lat   <= NUM_SCANS;
                                rept_lat  <= REPT_DELAY;
                                phcyc_lat <= PHCYC_EN;
                                SCAN_IDX  <= '0;
                                PHASE_CYC <= 1'b0;
                                ERR       <= 1'b0;
                                BUSY      <= 1'b1;
                                ack_cnt   <= '0;
                                state     <= S_LAUNCH;
                            end
                        end
                    end

                    S_LAUNCH: begin
                        if (PP_FSMSTAT) begin
                            PP_START <= 1'b0;
                            state    <= S_WAIT_END;
                        end else if (ack_cnt == ACK_LAST) begin
                            ERR      <= 1'b1;
                            PP_START <= 1'b0;
                            state    <= S_FINISH;
                        end else begin
                            ack_cnt  <= ack_cnt + ACK_W'(1);
                            PP_START <= 1'b1;
                        end
                    end

                    S_WAIT_END: begin
                        if (scan_end) begin
                            SCAN_DONE <= 1'b1;
                            SCAN_IDX  <= next_idx;
                            if (last_scan) begin
                                state <= S_FINISH;
                            end else begin
                                // Phase only moves here, when the pulse
                                // program has just gone idle.
                                if (phcyc_lat) begin
                                    PHASE_CYC <= ~PHASE_CYC;
                                end
                                ack_cnt <= '0;
                                state   <= (rept_lat == '0) ? S_LAUNCH : S_REPT_DLY;
                            end
                        end
                    end

                    S_REPT_DLY: begin
                        if (tmr_expire) begin
                            ack_cnt <= '0;
                            state   <= S_LAUNCH;
                        end
                    end

                    S_DRAIN: begin
                        if (!PP_FSMSTAT) begin
                            state <= S_FINISH;
                        end
                    end

                    S_FINISH: begin
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= S_IDLE;
                    end

                    default: begin
                        PP_START <= 1'b0;
                        BUSY     <= 1'b0;
                        state    <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign DBG_STATE = state;

endmodule

// File: doc/nmr_scan_sequencer.md
NMR_SCAN_SEQUENCER -- requirements
Module: nmr_scan_sequencer

Interface
REQ-001 SHALL have parameter SCAN_CNT_WIDTH, default 16, the width of the scan count and scan index.
REQ-002 SHALL have parameter REPT_DELAY_WIDTH, default 32, the width of the repetition delay in CLK cycles.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 1024, the maximum cycles to wait for PP_FSMSTAT to rise.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with ports as follows.
- CLK  in  1  system clock; all logic on posedge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  level; sampled only in IDLE to begin a multi-scan run.
- ABORT  in  1  level; terminates the run early.
- NUM_SCANS  in  SCAN_CNT_WIDTH  number of scans per run.
- REPT_DELAY  in  REPT_DELAY_WIDTH  idle cycles between the end of one scan and the next launch.
- PHCYC_EN  in  1  when 1, PHASE_CYC alternates per scan.
- PP_FSMSTAT  in  1  pulse-program busy flag.
- PP_START  out  1  pulse-program start request.
- PHASE_CYC  out  1  phase-cycling select to the pulse program.
- SCAN_IDX  out  SCAN_CNT_WIDTH  number of completed scans.
- BUSY  out  1  high from run accept through the FINISH cycle.
- SCAN_DONE  out  1  one-cycle pulse per completed scan.
- DONE  out  1  one-cycle pulse at end of run.
- ERR  out  1  sticky error: ack timeout or abort; cleared by the next accepted START.

Function
REQ-005 SHALL implement one-hot states IDLE, LAUNCH, WAIT_END, REPT_DLY, DRAIN, FINISH.
REQ-006 IDLE, START=1, ABORT=0, NUM_SCANS!=0: latch NUM_SCANS, REPT_DELAY and PHCYC_EN; SCAN_IDX<=0; PHASE_CYC<=0; ERR<=0; BUSY<=1; go to LAUNCH.
REQ-007 IDLE, START=1, NUM_SCANS=0: assert DONE for one cycle on the next edge; BUSY stays 0; remain in IDLE.
REQ-008 IDLE, START=1, ABORT=1: START is ignored.
REQ-009 LAUNCH: PP_START=1 and an ack counter runs; PP_FSMSTAT=1 sets PP_START<=0 and goes to WAIT_END.
REQ-010 LAUNCH: ACK_TIMEOUT cycles without PP_FSMSTAT set ERR<=1, PP_START<=0 and go to FINISH.
REQ-011 WAIT_END, PP_FSMSTAT=0: pulse SCAN_DONE and set SCAN_IDX<=SCAN_IDX+1.
- If the new index equals the latched count, go to FINISH.
- Otherwise, if PHCYC_EN is latched, toggle PHASE_CYC.
- Then go to REPT_DLY, or directly to LAUNCH when the latched delay is 0.
REQ-012 REPT_DLY SHALL last exactly the latched REPT_DELAY cycles, then go to LAUNCH.
- The first PP_START rises REPT_DELAY+1 cycles after the SCAN_DONE pulse.
REQ-013 PHASE_CYC SHALL change only in WAIT_END to REPT_DLY/LAUNCH transitions, never while PP_FSMSTAT=1.
REQ-014 ABORT=1 in any non-IDLE state: PP_START<=0 and ERR<=1.
- If PP_FSMSTAT=1, go to DRAIN; otherwise go to FINISH.
REQ-015 DRAIN SHALL wait for PP_FSMSTAT=0, then go to FINISH without incrementing SCAN_IDX.
REQ-016 FINISH: pulse DONE for one cycle, BUSY<=0, go to IDLE; SCAN_IDX and PHASE_CYC hold their values.
REQ-017 START while BUSY=1 SHALL be ignored.
REQ-018 SCAN_IDX SHALL never wrap: the count comparison uses the full SCAN_CNT_WIDTH, so the maximum is 2^SCAN_CNT_WIDTH-1 scans.
REQ-019 Input changes to NUM_SCANS, REPT_DELAY and PHCYC_EN during a run SHALL have no effect until the next accepted START.

Reset
REQ-020 RESET=1 SHALL asynchronously force state IDLE and every output to 0, and clear all counters.
REQ-021 RESET mid-run SHALL NOT wait for PP_FSMSTAT; PP_START drops immediately.

Structure
REQ-022 The state encodings and the ACK_TIMEOUT default SHALL reside in the shared package nmr_seq_pkg.
REQ-023 The repetition delay SHALL be a sub-module nmr_rept_delay_timer with ports load, value, and one-cycle expire; it serves REPT_DLY only.

Verification
REQ-024 The bench SHALL cover the following directed scenarios.
- Run: NUM_SCANS=4, REPT_DELAY=10, PHCYC_EN=1, PP model busy 50 cycles -> 4 SCAN_DONE pulses, PHASE_CYC sequence 0,1,0,1 at launches, DONE once, SCAN_IDX=4.
- Delay timing: REPT_DELAY=0 -> PP_START reasserted 1 cycle after SCAN_DONE; REPT_DELAY=10 -> 11 cycles after.
- Zero count: NUM_SCANS=0, START -> DONE the next cycle, BUSY never 1, PP_START never 1.
- Abort mid-scan: ABORT during scan 2 with PP_FSMSTAT=1 -> PP_START=0, DRAIN until PP_FSMSTAT=0, DONE, ERR=1, SCAN_IDX=1.
- Ack timeout: PP model never acks, ACK_TIMEOUT=1024 -> ERR=1 and DONE after 1024 LAUNCH cycles.
- Reset mid-REPT_DLY: RESET asserted -> all outputs 0 immediately; the next START runs normally.
